// File: rtl/window_minmax_tracker.sv
// ---------------------------------------------------------------------------
// window_minmax_tracker
//
// Purpose:
//   Streaming statistics stage that sits downstream of the n-bit comparator.
//   It accepts N-bit samples over a valid/ready handshake and groups them
//   into windows of WIN samples. For each window it tracks the running
//   minimum and maximum. It also counts how each sample relates to the one
//   before it (greater / smaller / equal). One result record per window is
//   presented on an output valid/ready handshake.
//
// Configuration:
//   SIGNED_CMP_EN - when defined, samples, min/max and every comparison are
//                   treated as two's complement signed N-bit values. When it
//                   is undefined, all comparisons are unsigned. The port list
//                   and timing are identical in both builds.
//
// Parameters:
//   N    - sample width in bits (N >= 2)
//   WIN  - samples per window (WIN >= 2)
//   CW   - count width, derived as $clog2(WIN); holds up to WIN-1
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   in_valid     in   in_data carries a sample
//   in_ready     out  block accepts a sample this cycle (high in ACCUM)
//   in_data      in   N-bit sample
//   out_valid    out  window result record is valid (high in DONE)
//   out_ready    in   consumer accepts the record
//   out_min      out  smallest sample in the window
//   out_max      out  largest sample in the window
//   out_greater  out  samples strictly greater than their predecessor
//   out_smaller  out  samples strictly smaller than their predecessor
//   out_equal    out  samples equal to their predecessor
// ---------------------------------------------------------------------------
module window_minmax_tracker #(
    parameter  int N   = 12,
    parameter  int WIN = 8,
    localparam int CW  = $clog2(WIN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_min,
    output logic [N-1:0]  out_max,
    output logic [CW-1:0] out_greater,
    output logic [CW-1:0] out_smaller,
    output logic [CW-1:0] out_equal
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t        state, state_nxt;

    logic [CW-1:0] idx_q,  idx_nxt;
    logic [N-1:0]  prev_q, prev_nxt;
    logic [N-1:0]  min_q,  min_nxt;
    logic [N-1:0]  max_q,  max_nxt;
    logic [CW-1:0] gt_q,   gt_nxt;
    logic [CW-1:0] lt_q,   lt_nxt;
    logic [CW-1:0] eq_q,   eq_nxt;

    logic          in_xfer;
    logic          out_xfer;
    logic          last_sample;
    logic          first_sample;

    // Single ordering primitive. The rest of the datapath uses only this
    // function, so the signed build changes the compare and nothing else.
    function automatic logic less_than(input logic [N-1:0] a,
                                       input logic [N-1:0] b);
`ifdef SIGNED_CMP_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    assign first_sample = (idx_q == '0);
    assign last_sample  = (idx_q == CW'(WIN - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        in_xfer   = 1'b0;
        out_xfer  = 1'b0;

        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                in_xfer  = in_valid;
                if (in_valid && last_sample) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_xfer  = out_ready;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Window statistics: next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        idx_nxt  = idx_q;
        prev_nxt = prev_q;
        min_nxt  = min_q;
        max_nxt  = max_q;
        gt_nxt   = gt_q;
        lt_nxt   = lt_q;
        eq_nxt   = eq_q;

        if (out_xfer) begin
            // The record has been consumed, so start the next window clean.
            idx_nxt  = '0;
            prev_nxt = '0;
            min_nxt  = '0;
            max_nxt  = '0;
            gt_nxt   = '0;
            lt_nxt   = '0;
            eq_nxt   = '0;
        end else if (in_xfer) begin
            prev_nxt = in_data;

            // The index holds at WIN-1 while DONE. This avoids relying on a
            // power-of-two wrap, and the output transfer clears the index.
            if (!last_sample) begin
                idx_nxt = idx_q + CW'(1);
            end

            if (first_sample) begin
                // Sample 0 has no predecessor. It seeds min/max/prev and
                // leaves the counts untouched.
                min_nxt = in_data;
                max_nxt = in_data;
            end else begin
                if (less_than(in_data, prev_q)) begin
                    lt_nxt = lt_q + CW'(1);
                end else if (less_than(prev_q, in_data)) begin
                    gt_nxt = gt_q + CW'(1);
                end else begin
                    eq_nxt = eq_q + CW'(1);
                end

                if (less_than(in_data, min_q)) begin
                    min_nxt = in_data;
                end
                if (less_than(max_q, in_data)) begin
                    max_nxt = in_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Window statistics: registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            prev_q <= '0;
            min_q  <= '0;
            max_q  <= '0;
            gt_q   <= '0;
            lt_q   <= '0;
            eq_q   <= '0;
        end else begin
            idx_q  <= idx_nxt;
            prev_q <= prev_nxt;
            min_q  <= min_nxt;
            max_q  <= max_nxt;
            gt_q   <= gt_nxt;
            lt_q   <= lt_nxt;
            eq_q   <= eq_nxt;
        end
    end

    // No input is accepted in DONE, so the registers stay frozen there.
    // The record therefore holds stable under backpressure without any
    // extra output latch.
    assign out_min     = min_q;
    assign out_max     = max_q;
    assign out_greater = gt_q;
    assign out_smaller = lt_q;
    assign out_equal   = eq_q;

endmodule

// File: tb/tb_window_minmax_tracker.sv
module tb_window_minmax_tracker;

    localparam int N   = 12;
    localparam int WIN = 4;
    localparam int CW  = $clog2(WIN);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_min;
    logic [N-1:0]  out_max;
    logic [CW-1:0] out_greater;
    logic [CW-1:0] out_smaller;
    logic [CW-1:0] out_equal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int mn;
        int mx;
        int g;
        int s;
        int e;
    } rec_t;

    rec_t exp_q[$];

    window_minmax_tracker #(.N(N), .WIN(WIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_greater (out_greater),
        .out_smaller (out_smaller),
        .out_equal   (out_equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int mn, input int mx, input int g, input int s, input int e);
        rec_t r;
        r.mn = mn; r.mx = mx; r.g = g; r.s = s; r.e = e;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Monitor: a record transfers on the next rising edge whenever
    // out_valid && out_ready is seen at the falling edge.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("rec_min",     int'(out_min),     r.mn);
                    chk("rec_max",     int'(out_max),     r.mx);
                    chk("rec_greater", int'(out_greater), r.g);
                    chk("rec_smaller", int'(out_smaller), r.s);
                    chk("rec_equal",   int'(out_equal),   r.e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset: hold for two edges, then release.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            chk("rst_in_ready",  int'(in_ready),    1);
            chk("rst_out_valid", int'(out_valid),   0);
            chk("rst_min",       int'(out_min),     0);
            chk("rst_max",       int'(out_max),     0);
            chk("rst_counts",    int'(out_greater) + int'(out_smaller) + int'(out_equal), 0);
            tick();
        end

        // Basic window: 5,99,66,66
        push(5, 99, 1, 1, 1);
        send(12'd5); send(12'd99); send(12'd66); send(12'd66);
        chk("latency_out_valid", int'(out_valid), 1);
        chk("latency_in_ready",  int'(in_ready),  0);
        idle(2);

        // Backpressure: window 20,30,10,40 held while 7 waits on the input.
        out_ready = 1'b0;
        push(10, 40, 2, 1, 0);
        send(12'd20); send(12'd30); send(12'd10); send(12'd40);
        in_valid = 1'b1;
        in_data  = 12'd7;
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready",  int'(in_ready),    0);
            chk("bp_out_valid", int'(out_valid),   1);
            chk("bp_min",       int'(out_min),     10);
            chk("bp_max",       int'(out_max),     40);
            chk("bp_greater",   int'(out_greater), 2);
            chk("bp_equal",     int'(out_equal),   0);
            tick();
        end
        out_ready = 1'b1;
        // 7 becomes sample 0 of the next window: 7,8,6,7
        push(6, 8, 2, 1, 0);
        send(12'd7); send(12'd8); send(12'd6); send(12'd7);
        idle(2);

        // Gapped input: 10 x4 with two idle cycles between samples.
        push(10, 10, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            send(12'd10);
            idle(2);
        end
        idle(2);

        // Reset mid-window discards 100,200.
        send(12'd100); send(12'd200);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_min",      int'(out_min),   0);
        chk("midrst_max",      int'(out_max),   0);
        chk("midrst_in_ready", int'(in_ready),  1);
        push(1, 4, 3, 0, 0);
        send(12'd1); send(12'd2); send(12'd3); send(12'd4);
        idle(2);

        // Signedness: 0xFFF,0x001,0x001,0x001
`ifdef SIGNED_CMP_EN
        push(12'hFFF, 12'h001, 1, 0, 2);
`else
        push(12'h001, 12'hFFF, 0, 1, 2);
`endif
        send(12'hFFF); send(12'h001); send(12'h001); send(12'h001);

        // Wait for the scoreboard to drain.
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        idle(2);
        chk("final_out_valid", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_minmax_tracker.md
Name: window_minmax_tracker

Overview:
- Sequential companion stage downstream of the n-bit comparator.
- Accepts a stream of N-bit samples over a valid/ready handshake and groups them into windows of WIN samples.
- Per window, tracks running min and max, and counts the relation of each sample to its predecessor (greater / smaller / equal).
- Presents one result record per window on an output valid/ready handshake for consumption by control/logging logic.

Parameters:
- N, 12: sample data width in bits (N >= 2).
- WIN, 8: samples per window (WIN >= 2).
- CW, $clog2(WIN): count width; holds up to WIN-1. Derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  N  sample value.
- out_valid  output  1  window result record is valid.
- out_ready  input  1  consumer accepts the record.
- out_min  output  N  smallest sample in the window.
- out_max  output  N  largest sample in the window.
- out_greater  output  CW  count of samples strictly greater than the previous sample.
- out_smaller  output  CW  count of samples strictly smaller than the previous sample.
- out_equal  output  CW  count of samples equal to the previous sample.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Enters ACCUM.
  - Sample counter, prev, min, max and all counts are cleared to 0; out_valid=0.
  - All out_* data outputs read 0.
  - Reset mid-window or mid-DONE discards all partial or pending results.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready at a clk edge.
  - Output transfer occurs when out_valid && out_ready at a clk edge.
- FSM, two states:
  - ACCUM:
    - in_ready=1, out_valid=0.
    - On a transfer of the first sample (idx 0): min=max=prev=in_data; counts unchanged at 0.
    - On transfer of sample idx k>0:
      - Compare in_data vs prev.
      - Increment exactly one of greater/smaller/equal.
      - Update min if in_data < min; update max if in_data > max.
      - prev=in_data.
    - On transfer of sample idx WIN-1: go to DONE.
  - DONE:
    - in_ready=0, out_valid=1.
    - Outputs hold stable until the output transfer.
    - On output transfer: clear the counter and stats, go to ACCUM.
- Latency: out_valid rises on the cycle after the WIN-th input transfer.
- Throughput: one result per WIN+1 cycles minimum (one DONE bubble per window).
- in_valid gaps: no state change on cycles without a transfer. Gaps of any length are allowed.
- in_valid held high while in DONE: sample not accepted; it is accepted on the first ACCUM cycle after the output transfer.
- Backpressure: out_ready low holds DONE indefinitely; in_data is ignored.
- Invariant: greater+smaller+equal == WIN-1 at every output transfer.
- Comparisons are unsigned by default. No overflow is possible given CW.

Optional Feature:
- Macro: SIGNED_CMP_EN.
- Defined: in_data, min/max and all comparisons are two's complement signed N-bit.
- Undefined: all comparisons are unsigned.
- Port list and timing are identical either way.

Test Plan:
- Reset: hold rst_n=0 two cycles, then release -> in_ready=1, out_valid=0, all outputs 0; reset value holds on the first cycle after release.
- Basic window, WIN=4, N=12, in_valid continuous, samples 5,99,66,66 -> next cycle: out_valid=1, out_min=5, out_max=99, greater=1, smaller=1, equal=1; record accepted with out_ready=1.
- Backpressure: complete a window, hold out_ready=0 for 3 cycles with in_valid=1 and in_data=7 -> outputs stable, in_ready=0, sample 7 not counted. Raise out_ready -> 7 becomes idx 0 of the next window.
- Gapped input: WIN=4, samples 10,10,10,10 with 2 idle cycles between each -> min=max=10, equal=3, greater=smaller=0.
- Reset mid-window: accept 100,200, pulse rst_n=0 for one cycle, then feed 1,2,3,4 -> min=1, max=4, greater=3; the values 100/200 are absent.
- Signed, WIN=2, samples 0xFFF then 0x001:
  - With SIGNED_CMP_EN: min=0xFFF, max=0x001, greater=1.
  - Without SIGNED_CMP_EN: min=0x001, max=0xFFF, smaller=1.
